pc_stack_counter: RTL and testbench

- Parametrised program-counter unit for the tiny CPU.
- Extends the basic load/increment counter with a configurable increment step and a signed PC-relative branch.
- Adds a hardware return-address stack (call/return) of configurable depth, with full/empty status and sticky error flags.
- Sits between the instruction decoder, which issues the one-cycle op strobes, and instruction memory, which is addressed by q.

---
 rtl/pc_stack_counter.sv | 110 +++++++++++
 tb/tb_pc_stack_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_counter.sv
// rtl/pc_stack_counter.sv - program counter with step increment, relative branch and return-address stack
module pc_stack_counter #(
  parameter int N     = 16,
  parameter int STEP  = 1,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           branch,
  input  logic           call,
  input  logic           ret,
  input  logic           inc,
  input  logic           clr_err,
  input  logic [N-1:0]   d,
  input  logic [N-1:0]   off,
  output logic [N-1:0]   q,
  output logic [SPW-1:0] depth,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           unf
);

  // Stack index width; a one-entry stack still needs a 1-bit index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]   pc_q, pc_d;
  logic [SPW-1:0] depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [N-1:0]   stack_q [DEPTH];
  logic [N-1:0]   stack_d [DEPTH];

  logic [AW-1:0]  push_idx;
  logic [AW-1:0]  pop_idx;
  logic [N-1:0]   pc_next_seq;
  logic           full_w;
  logic           empty_w;

  assign full_w      = (depth_q == SPW'(DEPTH));
  assign empty_w     = (depth_q == '0);
  assign push_idx    = depth_q[AW-1:0];
  assign pop_idx     = AW'(depth_q - SPW'(1));
  assign pc_next_seq = pc_q + N'(STEP);

  // Next-state: one op per cycle in priority order; losing strobes have no side effects.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end

    if (load) begin
      pc_d = d;
    end else if (branch) begin
      pc_d = pc_q + off;
    end else if (call) begin
      if (full_w) begin
        ovf_d = 1'b1;
      end else begin
        stack_d[push_idx] = pc_next_seq;
        depth_d           = depth_q + SPW'(1);
        pc_d              = d;
      end
    end else if (ret) begin
      if (empty_w) begin
        unf_d = 1'b1;
      end else begin
        pc_d    = stack_q[pop_idx];
        depth_d = depth_q - SPW'(1);
      end
    end else if (inc) begin
      pc_d = pc_next_seq;
    end
  end

  // State registers; reset aborts any in-flight push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign q     = pc_q;
  assign depth = depth_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// tb/tb_pc_stack_counter.sv - directed self-checking bench for pc_stack_counter
module tb_pc_stack_counter;

  logic        clk;
  logic        reset;
  logic        load, branch, call, ret, inc, clr_err;
  logic [15:0] d, off;

  logic [15:0] q, q4, q1;
  logic [2:0]  depth, depth4;
  logic [0:0]  depth1;
  logic        full, empty, ovf, unf;
  logic        full4, empty4, ovf4, unf4;
  logic        full1, empty1, ovf1, unf1;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack_counter #(.N(16), .STEP(1), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .load(load), .branch(branch), .call(call), .ret(ret),
    .inc(inc), .clr_err(clr_err), .d(d), .off(off), .q(q), .depth(depth),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  pc_stack_counter #(.N(16), .STEP(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .load(load), .branch(branch), .call(call), .ret(ret),
    .inc(inc), .clr_err(clr_err), .d(d), .off(off), .q(q4), .depth(depth4),
    .full(full4), .empty(empty4), .ovf(ovf4), .unf(unf4)
  );

  pc_stack_counter #(.N(16), .STEP(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .branch(branch), .call(call), .ret(ret),
    .inc(inc), .clr_err(clr_err), .d(d), .off(off), .q(q1), .depth(depth1),
    .full(full1), .empty(empty1), .ovf(ovf1), .unf(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 0; branch = 0; call = 0; ret = 0; inc = 0; clr_err = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    d = '0; off = '0;
    #12;
    check_val("rst_q", q, 0);
    check_val("rst_depth", depth, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_unf", unf, 0);
    reset = 1'b1;

    // sequential increment
    inc = 1;
    step(); check_val("inc1", q, 1);
    step(); check_val("inc2", q, 2);
    step(); check_val("inc3", q, 3);
    check_val("inc_empty", empty, 1);
    check_val("inc_depth", depth, 0);
    idle();

    // asynchronous reset mid-cycle
    #3 reset = 1'b0;
    #1 check_val("async_rst_q", q, 0);
    reset = 1'b1;

    // load, negative branch, wrap
    load = 1; d = 16'h1234;
    step(); check_val("load", q, 16'h1234);
    idle(); branch = 1; off = 16'hFFFE;
    step(); check_val("branch_neg", q, 16'h1232);
    idle(); load = 1; d = 16'hFFFF;
    step(); check_val("load_ffff", q, 16'hFFFF);
    idle(); inc = 1;
    step(); check_val("inc_wrap", q, 16'h0000);

    // nested call / ret
    idle(); load = 1; d = 16'h0010;
    step(); check_val("load_10", q, 16'h0010);
    idle(); call = 1; d = 16'h0100;
    step(); check_val("call1_q", q, 16'h0100); check_val("call1_depth", depth, 1);
    d = 16'h0200;
    step(); check_val("call2_q", q, 16'h0200); check_val("call2_depth", depth, 2);
    idle(); ret = 1;
    step(); check_val("ret1_q", q, 16'h0101); check_val("ret1_depth", depth, 1);
    step(); check_val("ret2_q", q, 16'h0011); check_val("ret2_depth", depth, 0);
    check_val("ret2_empty", empty, 1);

    // fill to DEPTH, then overflow
    idle(); load = 1; d = 16'h0000;
    step();
    idle(); call = 1;
    for (int i = 0; i < 4; i++) begin
      d = 16'((i + 1) << 12);
      step();
    end
    check_val("fill_q", q, 16'h4000);
    check_val("fill_depth", depth, 4);
    check_val("fill_full", full, 1);
    check_val("fill_ovf", ovf, 0);
    d = 16'h5000;
    step();
    check_val("ovf_q", q, 16'h4000);
    check_val("ovf_depth", depth, 4);
    check_val("ovf_flag", ovf, 1);

    // unwind in LIFO order
    idle(); ret = 1;
    step(); check_val("pop_a", q, 16'h3001);
    step(); check_val("pop_b", q, 16'h2001);
    step(); check_val("pop_c", q, 16'h1001);
    step(); check_val("pop_d", q, 16'h0001);
    check_val("pop_depth", depth, 0);
    check_val("ovf_sticky", ovf, 1);

    // underflow, clear-vs-set race, plain clear
    step();
    check_val("unf_q", q, 16'h0001);
    check_val("unf_depth", depth, 0);
    check_val("unf_flag", unf, 1);
    clr_err = 1;
    step();
    check_val("unf_set_wins", unf, 1);
    check_val("ovf_cleared", ovf, 0);
    idle(); clr_err = 1;
    step();
    check_val("unf_cleared", unf, 0);
    check_val("clr_q_hold", q, 16'h0001);

    // priority: load beats call and inc
    idle(); load = 1; call = 1; inc = 1; d = 16'h0040;
    step();
    check_val("prio_q", q, 16'h0040);
    check_val("prio_depth", depth, 0);
    check_val("prio_ovf", ovf, 0);

    // STEP=4 and DEPTH=1 instances
    idle();
    reset = 1'b0;
    #2;
    check_val("d1_rst_empty", empty1, 1);
    check_val("d1_rst_full", full1, 0);
    reset = 1'b1;
    load = 1; d = 16'h0008;
    step(); check_val("s4_load", q4, 16'h0008);
    idle(); inc = 1;
    step(); check_val("s4_inc", q4, 16'h000C);
    idle(); call = 1; d = 16'h0100;
    step();
    check_val("s4_call_q", q4, 16'h0100);
    check_val("s4_call_depth", depth4, 1);
    check_val("d1_call_full", full1, 1);
    check_val("d1_call_empty", empty1, 0);
    d = 16'h0300;
    step();
    check_val("d1_ovf", ovf1, 1);
    check_val("d1_ovf_q", q1, 16'h0100);
    idle(); ret = 1;
    step();
    step();
    check_val("s4_ret_q", q4, 16'h0010);
    check_val("d1_ret_q", q1, 16'h000A);
    check_val("d1_ret_full", full1, 0);
    check_val("d1_ret_empty", empty1, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
